stream_mux_rr: RTL

- Parametrised successor to the combinational 4x1 mux: an N-channel streaming packet multiplexer.
- Each input channel carries a valid/ready/last stream.
- A round-robin arbiter locks onto one channel for a whole packet and forwards it through a registered output stage.
- Sits between multiple packet sources and a single downstream consumer.

---
 rtl/stream_mux_rr_if.sv | 28 ++
 rtl/stream_mux_rr.sv | 118 +++++++++++
 2 files changed

// File: rtl/stream_mux_rr_if.sv
// Bundle of the mux's N_CH valid/ready/last input channels and its single output stream.
// The master side drives the inputs and out_ready. The slave side is the mux itself.
interface stream_mux_rr_if #(
   parameter int unsigned N_CH   = 4,
   parameter int unsigned DATA_W = 8
);
   localparam int unsigned SEL_W = $clog2(N_CH);

   logic [N_CH-1:0]        in_valid;
   logic [N_CH*DATA_W-1:0] in_data;
   logic [N_CH-1:0]        in_last;
   logic [N_CH-1:0]        in_ready;
   logic                   out_valid;
   logic [DATA_W-1:0]      out_data;
   logic                   out_last;
   logic [SEL_W-1:0]       out_sel;
   logic                   out_ready;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_sel
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_sel
   );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel packet stream mux: grants one channel for a whole packet and drives a registered output.
// Define STREAM_MUX_FIXED_PRIO_EN to use fixed priority (lowest index wins) instead of round-robin.
module stream_mux_rr #(
   parameter int unsigned N_CH   = 4,
   parameter int unsigned DATA_W = 8
) (
   input logic           clk,
   input logic           rst,
   stream_mux_rr_if.slave io_bus
);
   localparam int unsigned SEL_W = $clog2(N_CH);

   typedef enum logic {StIdle, StLock} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [SEL_W-1:0]  r_grant;
   logic [SEL_W-1:0]  w_grant_next;
   logic [SEL_W-1:0]  w_pick;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_last;
   logic [SEL_W-1:0]  r_out_sel;

   logic              w_any_valid;
   logic              w_out_free;
   logic              w_take;
   logic              w_grant_valid;
   logic              w_grant_last;
   logic [DATA_W-1:0] w_grant_data;
   logic [N_CH-1:0]   w_in_ready;

   assign w_any_valid   = |io_bus.in_valid;
   assign w_out_free    = !r_out_valid || io_bus.out_ready;
   assign w_grant_valid = io_bus.in_valid[r_grant];
   assign w_grant_last  = io_bus.in_last[r_grant];
   assign w_grant_data  = DATA_W'(io_bus.in_data >> (r_grant * DATA_W));
   assign w_in_ready    = (r_state == StLock && w_out_free) ? (N_CH'(1) << r_grant) : '0;
   assign w_take        = (r_state == StLock) && w_grant_valid && w_out_free;

`ifdef STREAM_MUX_FIXED_PRIO_EN
   // Descending scan so the lowest asserted index is written last and wins.
   always_comb begin
      w_pick = '0;
      for (int unsigned i = N_CH; i > 0; i--) begin
         if (io_bus.in_valid[SEL_W'(i - 1)]) w_pick = SEL_W'(i - 1);
      end
   end
`else
   logic [SEL_W-1:0] r_last_grant;
   logic [SEL_W-1:0] w_idx;

   // Scan offsets N_CH..1 so offset 1 (just after last_grant) is written last and wins;
   // offset N_CH is last_grant itself, the lowest priority.
   always_comb begin
      w_pick = r_last_grant;
      w_idx  = '0;
      for (int unsigned k = N_CH; k > 0; k--) begin
         w_idx = SEL_W'((32'(r_last_grant) + k) % N_CH);
         if (io_bus.in_valid[w_idx]) w_pick = w_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= SEL_W'(N_CH - 1);
      end else if (w_take && w_grant_last) begin
         r_last_grant <= r_grant;
      end
   end
`endif

   always_comb begin
      w_state_next = r_state;
      w_grant_next = r_grant;
      unique case (r_state)
         StIdle: begin
            if (w_any_valid) begin
               w_state_next = StLock;
               w_grant_next = w_pick;
            end
         end
         StLock: begin
            if (w_take && w_grant_last) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_grant     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_sel   <= '0;
      end else begin
         r_state <= w_state_next;
         r_grant <= w_grant_next;
         if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_last  <= w_grant_last;
            r_out_sel   <= r_grant;
         end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.out_data  = r_out_data;
   assign io_bus.out_last  = r_out_last;
   assign io_bus.out_sel   = r_out_sel;
endmodule
